fetch_refill: RTL and testbench

Parametrised instruction-fetch stage with an integrated direct-mapped instruction cache and a miss-refill state machine. It holds the PC and serves instructions on cache hits with zero latency. On a miss it requests the line-aligned block from memory and streams it in over a configurable number of beats. Branch redirects and cache flushes that arrive during a refill are captured and applied once the refill completes. It sits between the memory/refill port and decode, and drives the instruction and PC into the decode pipeline register.

---
 rtl/fetch_refill.sv | 192 +++++++++++++++++++
 tb/tb_fetch_refill.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_refill.sv
// fetch_refill: instruction-fetch stage with a direct-mapped I-cache and a
// miss-refill FSM. Hits are served combinationally from the current PC.
// A miss requests the line-aligned block and streams it in over BEATS beats.
// Redirects and flushes seen mid-refill are held and applied on completion.
module fetch_refill #(
    parameter int          SETS       = 32,
    parameter int          LINE_WORDS = 4,
    parameter int          BEAT_BITS  = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 advance,
    input  logic                 branch,
    input  logic [31:0]          branch_target,
    input  logic                 flush_all,
    output logic                 mem_req,
    output logic [31:0]          mem_addr,
    input  logic                 mem_ack,
    input  logic                 mem_beat_valid,
    input  logic [BEAT_BITS-1:0] mem_beat,
    output logic [31:0]          inst,
    output logic                 inst_valid,
    output logic [31:0]          pc_out,
    output logic                 busy
);

    localparam int IDX_BITS  = $clog2(SETS);
    localparam int OFF_BITS  = $clog2(LINE_WORDS * 4);
    localparam int WORD_BITS = OFF_BITS - 2;
    localparam int TAG_BITS  = 32 - IDX_BITS - OFF_BITS;
    localparam int BEATS     = (LINE_WORDS * 32) / BEAT_BITS;
    localparam int WPB       = BEAT_BITS / 32;
    localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;

    logic [31:0]         pc_reg, pc_next;
    logic [1:0]          state_reg, state_next;
    logic [CNT_W-1:0]    beat_cnt_reg, beat_cnt_next;
    logic                pend_v_reg, pend_v_next;
    logic [31:0]         pend_pc_reg, pend_pc_next;
    logic                pend_flush_reg, pend_flush_next;
    logic [SETS-1:0]     valid_reg, valid_next;

    logic [TAG_BITS-1:0] tag_array [SETS];
    logic [31:0]         word_rd [LINE_WORDS];

    logic [TAG_BITS-1:0]  pc_tag;
    logic [IDX_BITS-1:0]  pc_idx;
    logic [WORD_BITS-1:0] pc_word;
    logic                 hit;
    logic                 redirect;
    logic [31:0]          target_aligned;
    logic                 beat_we;
    logic                 last_beat;
    logic                 unused_target_bits;

    // The low target bits never reach the PC; this keeps them visibly consumed.
    assign unused_target_bits = ^branch_target[1:0];

    assign pc_tag         = pc_reg[31:IDX_BITS+OFF_BITS];
    assign pc_idx         = pc_reg[IDX_BITS+OFF_BITS-1:OFF_BITS];
    assign pc_word        = pc_reg[OFF_BITS-1:2];
    assign hit            = valid_reg[pc_idx] && (tag_array[pc_idx] == pc_tag);
    assign redirect       = advance && branch;
    assign target_aligned = {branch_target[31:2], 2'b00};
    assign beat_we        = (state_reg == ST_FILL) && mem_beat_valid;
    assign last_beat      = beat_we && (beat_cnt_reg == LAST_BEAT);

    // Next-state logic for the PC, the refill FSM and the pending redirect/flush.
    always_comb begin
        pc_next         = pc_reg;
        state_next      = state_reg;
        beat_cnt_next   = beat_cnt_reg;
        pend_v_next     = pend_v_reg;
        pend_pc_next    = pend_pc_reg;
        pend_flush_next = pend_flush_reg;
        valid_next      = valid_reg;

        case (state_reg)
            ST_RUN: begin
                if (redirect) begin
                    pc_next = target_aligned;
                end else if (advance && hit) begin
                    pc_next = pc_reg + 32'd4;
                end
                // A flush wins over the miss; the lookup simply repeats next cycle.
                if (flush_all) begin
                    valid_next = '0;
                end else if (!hit && !redirect) begin
                    state_next         = ST_REQ;
                    valid_next[pc_idx] = 1'b0;
                end
            end
            ST_REQ, ST_FILL: begin
                // The PC is frozen on the missing line; redirects and flushes wait.
                if (redirect) begin
                    pend_v_next  = 1'b1;
                    pend_pc_next = target_aligned;
                end
                if (flush_all) begin
                    pend_flush_next = 1'b1;
                end
                if (state_reg == ST_REQ) begin
                    if (mem_ack) begin
                        state_next    = ST_FILL;
                        beat_cnt_next = '0;
                    end
                end else if (beat_we) begin
                    beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    if (last_beat) begin
                        state_next    = ST_RUN;
                        beat_cnt_next = '0;
                        if (pend_v_next) begin
                            pc_next = pend_pc_next;
                        end
                        pend_v_next = 1'b0;
                        if (pend_flush_next) begin
                            valid_next = '0;
                        end else begin
                            valid_next[pc_idx] = 1'b1;
                        end
                        pend_flush_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Control and PC registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg         <= RESET_PC;
            state_reg      <= ST_RUN;
            beat_cnt_reg   <= '0;
            pend_v_reg     <= 1'b0;
            pend_pc_reg    <= '0;
            pend_flush_reg <= 1'b0;
            valid_reg      <= '0;
        end else begin
            pc_reg         <= pc_next;
            state_reg      <= state_next;
            beat_cnt_reg   <= beat_cnt_next;
            pend_v_reg     <= pend_v_next;
            pend_pc_reg    <= pend_pc_next;
            pend_flush_reg <= pend_flush_next;
            valid_reg      <= valid_next;
        end
    end

    // Tag is written with the last beat, in the same edge that sets valid.
    always_ff @(posedge clk) begin
        if (rst_n && last_beat) begin
            tag_array[pc_idx] <= pc_tag;
        end
    end

    // One storage column per word of the line; each column takes its lane of
    // the beat whose slot number matches the word's position in the line.
    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
            localparam int SLOT = gi / WPB;
            localparam int LANE = gi % WPB;
            logic [31:0] word_mem [SETS];

            // Capture this word's lane when its beat arrives.
            always_ff @(posedge clk) begin
                if (rst_n && beat_we && (beat_cnt_reg == CNT_W'(SLOT))) begin
                    word_mem[pc_idx] <= mem_beat[LANE*32 +: 32];
                end
            end

            assign word_rd[gi] = word_mem[pc_idx];
        end
    endgenerate

    assign inst       = word_rd[pc_word];
    assign inst_valid = (state_reg == ST_RUN) && hit;
    assign pc_out     = pc_reg;
    assign busy       = (state_reg != ST_RUN);
    assign mem_req    = (state_reg == ST_REQ);
    assign mem_addr   = {pc_reg[31:OFF_BITS], {OFF_BITS{1'b0}}};

endmodule

// File: tb/tb_fetch_refill.sv
// Testbench for fetch_refill at default parameters (4-word lines, 2 beats).
// Stimulus pushes expected fetched instructions and expected line requests
// into queues; a negedge monitor pops and compares whenever the DUT consumes
// an instruction (inst_valid && advance) or hands off a request (mem_req && mem_ack).
module tb_fetch_refill;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        advance;
    logic        branch;
    logic [31:0] branch_target;
    logic        flush_all;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_beat_valid;
    logic [63:0] mem_beat;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [63:0] inst_q [$];
    logic [31:0] req_q  [$];
    logic [63:0] mon_inst_exp;
    logic [31:0] mon_req_exp;

    always #5 clk = ~clk;

    fetch_refill #(
        .SETS       (32),
        .LINE_WORDS (4),
        .BEAT_BITS  (64),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .advance        (advance),
        .branch         (branch),
        .branch_target  (branch_target),
        .flush_all      (flush_all),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_beat_valid (mem_beat_valid),
        .mem_beat       (mem_beat),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .pc_out         (pc_out),
        .busy           (busy)
    );

    // Monitor: compare every consumed instruction and every accepted request.
    always @(negedge clk) begin
        if (rst_n && inst_valid && advance) begin
            checks++;
            if (inst_q.size() == 0) begin
                errors++;
                $display("FAIL inst_unexpected: got pc=%h inst=%h, required no fetch", pc_out, inst);
            end else begin
                mon_inst_exp = inst_q.pop_front();
                if ({pc_out, inst} !== mon_inst_exp) begin
                    errors++;
                    $display("FAIL inst: got pc=%h inst=%h, required pc=%h inst=%h",
                             pc_out, inst, mon_inst_exp[63:32], mon_inst_exp[31:0]);
                end else begin
                    $display("fetch pc=%h inst=%h ok", pc_out, inst);
                end
            end
        end
        if (rst_n && mem_req && mem_ack) begin
            checks++;
            if (req_q.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected: got addr=%h, required no request", mem_addr);
            end else begin
                mon_req_exp = req_q.pop_front();
                if (mem_addr !== mon_req_exp) begin
                    errors++;
                    $display("FAIL req_addr: got %h, required %h", mem_addr, mon_req_exp);
                end else begin
                    $display("request addr=%h ok", mem_addr);
                end
            end
        end
    end

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic start_req(input logic [31:0] line);
        int n;
        n = 0;
        req_q.push_back(line);
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", {31'b0, mem_req}, 32'd1);
        check("req_busy_invalid", {30'b0, busy, inst_valid}, 32'd2);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic beat(input logic [31:0] line, input int k);
        mem_beat       = {mem_word(line + 32'(8 * k) + 32'd4), mem_word(line + 32'(8 * k))};
        mem_beat_valid = 1'b1;
        tick();
        mem_beat_valid = 1'b0;
    endtask

    task automatic refill(input logic [31:0] line);
        start_req(line);
        beat(line, 0);
        beat(line, 1);
    endtask

    task automatic consume(input int n, input logic [31:0] pc0, input logic [31:0] inst0);
        advance = 1'b1;
        for (int i = 0; i < n; i++) begin
            inst_q.push_back({pc0 + 32'(4 * i), inst0 + 32'(i)});
            tick();
        end
        advance = 1'b0;
    endtask

    task automatic branch_to(input logic [31:0] tgt, input logic take,
                             input logic [31:0] epc, input logic [31:0] einst);
        if (take) inst_q.push_back({epc, einst});
        advance       = 1'b1;
        branch        = 1'b1;
        branch_target = tgt;
        tick();
        advance = 1'b0;
        branch  = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        advance        = 1'b0;
        branch         = 1'b0;
        branch_target  = '0;
        flush_all      = 1'b0;
        mem_ack        = 1'b0;
        mem_beat_valid = 1'b0;
        mem_beat       = '0;

        // Reset state
        tick();
        tick();
        check("rst_pc", pc_out, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        rst_n = 1'b1;

        // Cold start: line 0, then four sequential fetches
        refill(32'h0);
        check("cold_inst_valid", {31'b0, inst_valid}, 32'd1);
        consume(4, 32'h0, 32'h1);

        // Sequential miss at 0x10: RUN this cycle, REQ the next
        check("seqmiss_pc", pc_out, 32'h10);
        check("seqmiss_req0", {30'b0, mem_req, busy}, 32'd0);
        check("seqmiss_invalid", {31'b0, inst_valid}, 32'd0);
        tick();
        check("seqmiss_req1", {30'b0, mem_req, busy}, 32'd3);
        check("seqmiss_addr", mem_addr, 32'h10);

        // Redirect during FILL gaps: refill of 0x10 completes, then pc=0x40
        start_req(32'h10);
        beat(32'h10, 0);
        advance       = 1'b1;
        branch        = 1'b1;
        branch_target = 32'h43;
        tick();
        advance = 1'b0;
        branch  = 1'b0;
        tick();
        check("fill_gap_busy", {30'b0, busy, inst_valid}, 32'd2);
        beat(32'h10, 1);
        check("redir_pc", pc_out, 32'h40);
        check("redir_state", {30'b0, busy, inst_valid}, 32'd0);
        refill(32'h40);
        consume(2, 32'h40, 32'h11);
        branch_to(32'h10, 1'b1, 32'h48, 32'h13);
        check("line10_hit", {31'b0, inst_valid}, 32'd1);
        consume(1, 32'h10, 32'h5);

        // Conflict: 0x200 evicts 0x000 (same index)
        branch_to(32'h200, 1'b1, 32'h14, 32'h6);
        refill(32'h200);
        consume(1, 32'h200, 32'h81);
        branch_to(32'h0, 1'b1, 32'h204, 32'h82);
        check("evict_miss", {31'b0, inst_valid}, 32'd0);
        refill(32'h0);
        consume(1, 32'h0, 32'h1);

        // Flush in RUN: next cycle misses at the current pc
        check("preflush_hit", {31'b0, inst_valid}, 32'd1);
        flush_all = 1'b1;
        tick();
        flush_all = 1'b0;
        check("flush_invalid", {31'b0, inst_valid}, 32'd0);
        check("flush_pc", pc_out, 32'h4);
        tick();
        check("flush_req", {31'b0, mem_req}, 32'd1);
        check("flush_addr", mem_addr, 32'h0);
        refill(32'h0);
        consume(1, 32'h4, 32'h2);

        // Flush during FILL: the just-filled line misses again
        branch_to(32'h80, 1'b1, 32'h8, 32'h3);
        start_req(32'h80);
        beat(32'h80, 0);
        flush_all = 1'b1;
        tick();
        flush_all = 1'b0;
        beat(32'h80, 1);
        check("fillflush_pc", pc_out, 32'h80);
        check("fillflush_invalid", {31'b0, inst_valid}, 32'd0);
        tick();
        check("fillflush_req", {31'b0, mem_req}, 32'd1);
        refill(32'h80);
        consume(1, 32'h80, 32'h21);

        // Reset mid-FILL: stale second beat ignored, line misses again
        branch_to(32'h100, 1'b1, 32'h84, 32'h22);
        start_req(32'h100);
        beat(32'h100, 0);
        rst_n = 1'b0;
        tick();
        check("midrst_pc", pc_out, 32'h0);
        check("midrst_busy_req", {30'b0, busy, mem_req}, 32'd0);
        rst_n = 1'b1;
        beat(32'h100, 1);
        check("midrst_req", {31'b0, mem_req}, 32'd1);
        check("midrst_addr", mem_addr, 32'h0);
        refill(32'h0);
        consume(1, 32'h0, 32'h1);
        branch_to(32'h100, 1'b1, 32'h4, 32'h2);
        check("midrst_line_miss", {31'b0, inst_valid}, 32'd0);
        refill(32'h100);
        consume(1, 32'h100, 32'h41);

        tick();
        tick();
        check("inst_q_drained", 32'(inst_q.size()), 32'd0);
        check("req_q_drained", 32'(req_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
